au_result_collector: RTL and testbench

Digit-serial result collector sitting directly downstream of the WIDTH-bit add/subtract core. It accepts one sum digit and carry-out per handshake, least-significant digit first, assembles them into a DIGITS-wide result word, derives word-level flags and presents the finished word on a valid/ready output port. The arithmetic unit's register file and display path consume its output.

---
 rtl/au_result_collector.sv | 156 +++++++++++++++
 tb/tb_au_result_collector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_result_collector.sv
// au_result_collector
//   Collects sum digits from the add/subtract core, least-significant first,
//   into a DIGITS-wide word and presents it with carry, zero and digit-count
//   flags on a valid/ready output port.
//   Optional feature macro: HPAU_COLLECT_NEG_EN adds out_neg (sign of the
//   closing digit's MSB, i.e. the sign of the two's-complement result).
module au_result_collector #(
  parameter int  WIDTH  = 4,
  parameter int  DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_s,
  input  logic                      in_cout,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*DIGITS-1:0]   out_result,
  output logic                      out_carry,
  output logic                      out_zero,
`ifdef HPAU_COLLECT_NEG_EN
  output logic                      out_neg,
`endif
  output logic [CW-1:0]             out_count
);

  localparam int              RW       = WIDTH * DIGITS;
  localparam logic [CW-1:0]   LAST_IDX = CW'(DIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic [CW-1:0]   count_q, count_d;
`ifdef HPAU_COLLECT_NEG_EN
  logic            neg_q, neg_d;
`endif

  logic            accept;
  logic            close;
  logic            digit_zero;
  logic [RW-1:0]   merged;

  // Handshake signals come straight from the state; nothing bypasses DONE.
  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && (state_q == COLLECT);
  assign close      = accept && (in_last || (idx_q == LAST_IDX));
  assign digit_zero = (in_s == '0);

  // Insert the incoming digit at position idx; the first digit of a word
  // starts from a cleared word so unused upper digits read as zero.
  always_comb begin
    merged = (idx_q == '0) ? '0 : result_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == CW'(k)) begin
        merged[k*WIDTH +: WIDTH] = in_s;
      end
    end
  end

  // Next-state and datapath update: digits accumulate in COLLECT, the word
  // is frozen in DONE until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    count_d  = count_q;
`ifdef HPAU_COLLECT_NEG_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          result_d = merged;
          carry_d  = in_cout;
          zero_d   = (idx_q == '0) ? digit_zero : (zero_q && digit_zero);
          if (close) begin
            count_d = idx_q + CW'(1);
            idx_d   = '0;
            state_d = DONE;
`ifdef HPAU_COLLECT_NEG_EN
            neg_d   = in_s[WIDTH-1];
`endif
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State register; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Output word and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      count_q  <= count_d;
    end
  end

`ifdef HPAU_COLLECT_NEG_EN
  // Sign of the closing digit, captured when the word closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign out_neg = neg_q;
`endif

  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_au_result_collector.sv
// Testbench for au_result_collector: directed scenarios with literal
// expectations plus randomized digit streams checked every cycle against a
// word-level reference model.
module tb_au_result_collector;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int RW     = WIDTH * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_s = '0;
  logic              in_cout = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RW-1:0]     out_result;
  logic              out_carry;
  logic              out_zero;
  logic [CW-1:0]     out_count;
`ifdef HPAU_COLLECT_NEG_EN
  logic              out_neg;
`endif

  au_result_collector #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_cout    (in_cout),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
`ifdef HPAU_COLLECT_NEG_EN
    .out_neg    (out_neg),
`endif
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_cyc     = 0;
  bit chk_en      = 1'b0;
  bit rnd         = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  logic [WIDTH-1:0] mq[$];
  bit               m_done  = 1'b0;
  bit               m_known = 1'b1;
  logic [RW-1:0]    m_res   = '0;
  logic             m_carry = 1'b0;
  logic             m_zero  = 1'b0;
  logic             m_neg   = 1'b0;
  int               m_cnt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_done = 1'b0; m_known = 1'b1;
      m_res = '0; m_carry = 1'b0; m_zero = 1'b0; m_neg = 1'b0; m_cnt = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      if (mq.size() == 0) m_known = 1'b0;
      mq.push_back(in_s);
      if (in_last || mq.size() == DIGITS) begin
        logic [WIDTH-1:0] top;
        m_res  = '0;
        m_zero = 1'b1;
        foreach (mq[k]) begin
          m_res = m_res | (RW'(mq[k]) << (WIDTH * k));
          if (mq[k] != '0) m_zero = 1'b0;
        end
        top     = mq[mq.size()-1];
        m_neg   = top[WIDTH-1];
        m_cnt   = mq.size();
        m_carry = in_cout;
        mq.delete();
        m_done  = 1'b1;
        m_known = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("in_ready", 32'(in_ready), 32'(!m_done));
      if (m_known) begin
        chk("out_result", 32'(out_result), 32'(m_res));
        chk("out_carry", 32'(out_carry), 32'(m_carry));
        chk("out_zero", 32'(out_zero), 32'(m_zero));
        chk("out_count", 32'(out_count), 32'(m_cnt));
`ifdef HPAU_COLLECT_NEG_EN
        chk("out_neg", 32'(out_neg), 32'(m_neg));
`endif
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [WIDTH-1:0] s, input logic c, input logic l);
    logic rdy;
    int   n;
    in_valid = 1'b1; in_s = s; in_cout = c; in_last = l;
    n = 0;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic release_word();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_result"}, 32'(out_result), 32'd0);
    chk({tag, "_out_carry"}, 32'(out_carry), 32'd0);
    chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
`ifdef HPAU_COLLECT_NEG_EN
    chk({tag, "_out_neg"}, 32'(out_neg), 32'd0);
`endif
  endtask

  initial begin
    int prev;
    logic [RW-1:0] held;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    // Full word, closed by digit count alone.
    send(4'h1, 1'b0, 1'b0); send(4'h2, 1'b0, 1'b0);
    send(4'h3, 1'b0, 1'b0); send(4'h4, 1'b1, 1'b0);
    in_valid = 1'b0;
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_result", 32'(out_result), 32'h4321);
    chk("full_carry", 32'(out_carry), 32'd1);
    chk("full_zero", 32'(out_zero), 32'd0);
    chk("full_count", 32'(out_count), 32'd4);
    release_word();

    // Reset in the middle of a word.
    send(4'h3, 1'b0, 1'b0); send(4'h5, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'h1, 1'b0, 1'b0); send(4'h2, 1'b0, 1'b0);
    send(4'h3, 1'b0, 1'b0); send(4'h4, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("after_reset_result", 32'(out_result), 32'h4321);
    chk("after_reset_count", 32'(out_count), 32'd4);
    release_word();

    // Short word after an all-ones word.
    repeat (4) send(4'hF, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("ones_result", 32'(out_result), 32'hFFFF);
    release_word();
    send(4'hA, 1'b0, 1'b0); send(4'h0, 1'b1, 1'b1);
    in_valid = 1'b0;
    chk("short_result", 32'(out_result), 32'h000A);
    chk("short_count", 32'(out_count), 32'd2);
    chk("short_carry", 32'(out_carry), 32'd1);
    release_word();

    // Zero word, then a word whose closing digit has its MSB set.
    repeat (4) send(4'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("zero_flag", 32'(out_zero), 32'd1);
    chk("zero_result", 32'(out_result), 32'd0);
    release_word();
    send(4'h0, 1'b0, 1'b0); send(4'h0, 1'b0, 1'b0);
    send(4'h0, 1'b0, 1'b0); send(4'h8, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("neg_word_zero", 32'(out_zero), 32'd0);
    chk("neg_word_result", 32'(out_result), 32'h8000);
`ifdef HPAU_COLLECT_NEG_EN
    chk("neg_flag", 32'(out_neg), 32'd1);
`endif
    release_word();

    // Backpressure: word held while a digit waits upstream.
    send(4'h2, 1'b0, 1'b1);
    held = out_result;
    chk("bp_held_value", 32'(held), 32'h0002);
    in_valid = 1'b1; in_s = 4'h7; in_cout = 1'b0; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_result", 32'(out_result), 32'(held));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_result", 32'(out_result), 32'h0007);
    chk("bp_next_count", 32'(out_count), 32'd1);
    in_valid = 1'b0;

    // Back-to-back single-digit words with the consumer always ready.
    out_ready = 1'b1;
    @(posedge clk); #1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'(i + 1), 1'(i), 1'b1);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev), 32'd2);
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized streams with random consumer backpressure.
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end else begin
        send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
      end
    end
    rnd = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
